ddu_btn_ctrl: RTL and testbench
===============================

DDU_BTN_CTRL -- requirements
Module: ddu_btn_ctrl

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 20000: consecutive stable cycles required to accept a button level change.
REQ-002 SHALL have parameter RPT_DELAY, default 5000000: hold cycles before inc/dec auto-repeat starts.
REQ-003 SHALL have parameter RPT_PERIOD, default 1000000: cycles between auto-repeat steps.
REQ-004 clk_out1  in  1  clock; all logic rising-edge on clk_out1.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 step_in  in  1  raw single-step button, asynchronous, bouncing.
REQ-007 inc_in  in  1  raw address-increment button, asynchronous, bouncing.
REQ-008 dec_in  in  1  raw address-decrement button, asynchronous, bouncing.
REQ-009 count  in  1  run mode; 1 = CPU free-running, 0 = single-step.
REQ-010 cpu_clk_en  out  1  CPU clock enable; 1 continuously in run mode, one-cycle pulse per step press otherwise.
REQ-011 step_busy  out  1  high while the step FSM is in FIRE or HOLD.
REQ-012 addr  out  8  memory/register inspection address for the debug display.
REQ-013 addr_chg  out  1  one-cycle pulse in the cycle after addr changes.

Function
REQ-014 Each raw button SHALL pass through its own two-flop synchronizer before any other use.
REQ-015 Each button SHALL have a debounce counter that counts consecutive cycles in which the synced value differs from the debounced value and clears to 0 on any matching cycle.
REQ-016 When a mismatch is seen with the counter at DEB_CYCLES-1, the debounced value SHALL take the synced value and the counter SHALL clear; pulses shorter than DEB_CYCLES cycles never reach the debounced value.
REQ-017 Step FSM states and transitions SHALL be: IDLE -> FIRE on debounced step high; FIRE -> HOLD unconditionally; HOLD -> IDLE on debounced step low.
REQ-018 step_pulse SHALL be 1 only in FIRE, giving exactly one pulse per accepted press regardless of hold length.
REQ-019 cpu_clk_en SHALL be registered and equal count | step_pulse.
REQ-020 Step presses accepted while count=1 SHALL still cycle the FSM but have no visible effect on cpu_clk_en.
REQ-021 An inc event SHALL occur on the debounced inc rising edge, then after RPT_DELAY further cycles of hold, then every RPT_PERIOD cycles while held; dec events SHALL follow the same rule independently.
REQ-022 An inc event SHALL set addr to addr+1 mod 256 (255 -> 0); a dec event SHALL set addr to addr-1 mod 256 (0 -> 255).
REQ-023 An inc event and a dec event in the same cycle SHALL leave addr unchanged with no addr_chg pulse.
REQ-024 If both debounced inc and dec are held, the repeat timers SHALL be held at 0 and no repeat events SHALL be generated until one is released.
REQ-025 Release of a button SHALL clear its repeat timer immediately; a new press restarts the full RPT_DELAY.
REQ-026 addr SHALL be independent of count and the step FSM.

Reset
REQ-027 When rst=1 at a clock edge, the following SHALL clear to 0: synchronizers, debounced values, debounce counters, repeat timers, addr, addr_chg, cpu_clk_en and step_busy, and the step FSM SHALL go to IDLE.
REQ-028 Reset during a hold or mid-debounce SHALL abort it; a button still held when rst falls SHALL be treated as a new press after DEB_CYCLES.
REQ-029 cpu_clk_en SHALL be 0 during reset even if count=1, and SHALL equal count from the first cycle after reset.

Verification (DEB_CYCLES=4, RPT_DELAY=20, RPT_PERIOD=8)
REQ-030 Bounce test: step_in toggles 1,0,1 with 2-cycle high/low widths, then is held high for 50 cycles while count=0 -> exactly one cpu_clk_en pulse, asserted DEB_CYCLES+2 to DEB_CYCLES+4 cycles after the stable rise.
REQ-031 Wrap test: reset, then one clean dec press -> addr=0xFF and one addr_chg pulse; then two inc presses -> addr=0x01.
REQ-032 Auto-repeat test: inc_in held for 60 cycles after the debounced rise -> addr increments at offsets 0, 20, 28, 36, 44 and 52, giving 6 increments in total.
REQ-033 Simultaneous test: inc_in and dec_in rise in the same cycle and are held for 40 cycles -> addr unchanged and no addr_chg pulse.
REQ-034 Mode and reset test: count=1 -> cpu_clk_en stays 1; rst is asserted while step is held -> cpu_clk_en=0, step_busy=0 and addr=0 in the cycle after rst.

Source files
------------

// File: rtl/ddu_btn_ctrl.sv
// ddu_btn_ctrl: debounced step/inc/dec buttons driving the CPU clock enable and debug address
module ddu_btn_ctrl #(
    parameter int DEB_CYCLES = 20000,
    parameter int RPT_DELAY  = 5000000,
    parameter int RPT_PERIOD = 1000000
) (
    input  logic       clk_out1,
    input  logic       rst,
    input  logic       step_in,
    input  logic       inc_in,
    input  logic       dec_in,
    input  logic       count,
    output logic       cpu_clk_en,
    output logic       step_busy,
    output logic [7:0] addr,
    output logic       addr_chg
);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int TW = $clog2(RPT_DELAY + 1);
    localparam logic [1:0] IDLE = 2'd0, FIRE = 2'd1, HOLD = 2'd2;

    logic [2:0] s1, s2, deb;
    logic [2:1] prev;
    logic [1:0] ev, state;
    logic       both;

    always_ff @(posedge clk_out1) begin
        if (rst) begin
            s1   <= '0;
            s2   <= '0;
            prev <= '0;
        end else begin
            s1   <= {dec_in, inc_in, step_in};
            s2   <= s1;
            prev <= deb[2:1];
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_deb
        logic [DW-1:0] cnt;
        logic          d;
        always_ff @(posedge clk_out1) begin
            if (rst) begin
                cnt <= '0;
                d   <= 1'b0;
            end else if (s2[i] == d) begin
                cnt <= '0;
            end else if (cnt == DW'(DEB_CYCLES - 1)) begin
                d   <= s2[i];
                cnt <= '0;
            end else begin
                cnt <= cnt + DW'(1);
            end
        end
        assign deb[i] = d;
    end

    assign both = deb[1] & deb[2];

    // timer wraps back one period below RPT_DELAY so every repeat fires on the same compare
    for (genvar j = 0; j < 2; j++) begin : g_rpt
        logic [TW-1:0] t;
        always_ff @(posedge clk_out1) begin
            if (rst || !deb[j+1] || both)
                t <= '0;
            else
                t <= (t == TW'(RPT_DELAY)) ? TW'(RPT_DELAY - RPT_PERIOD + 1) : t + TW'(1);
        end
        assign ev[j] = deb[j+1] & (~prev[j+1] | (t == TW'(RPT_DELAY)));
    end

    always_ff @(posedge clk_out1) begin
        if (rst) begin
            state      <= IDLE;
            cpu_clk_en <= 1'b0;
            addr       <= '0;
            addr_chg   <= 1'b0;
        end else begin
            state      <= (state == IDLE) ? (deb[0] ? FIRE : IDLE) :
                          (state == FIRE) ? HOLD : (deb[0] ? HOLD : IDLE);
            cpu_clk_en <= count | (state == FIRE);
            addr       <= (ev == 2'b01) ? addr + 8'd1 : (ev == 2'b10) ? addr - 8'd1 : addr;
            addr_chg   <= ^ev;
        end
    end

    assign step_busy = (state != IDLE);
endmodule

// File: tb/tb_ddu_btn_ctrl.sv
// tb_ddu_btn_ctrl: random and directed stimulus checked every cycle against a behavioural model
module tb_ddu_btn_ctrl;
    localparam int DEB = 4, RD = 20, RP = 8;

    logic       clk_out1 = 1'b0, rst = 1'b1, step_in = 1'b0, inc_in = 1'b0, dec_in = 1'b0, count = 1'b0;
    logic       cpu_clk_en, step_busy, addr_chg;
    logic [7:0] addr;
    int         total = 0, bad = 0;

    // model state: index 0 step, 1 inc, 2 dec
    bit m_s1[3], m_s2[3], m_deb[3], m_prev[3];
    bit hist[3][DEB];
    int m_h[3];
    int m_phase, m_addr;
    bit m_en, m_chg;

    always #5 clk_out1 = ~clk_out1;

    ddu_btn_ctrl #(.DEB_CYCLES(DEB), .RPT_DELAY(RD), .RPT_PERIOD(RP)) dut (
        .clk_out1(clk_out1), .rst(rst), .step_in(step_in), .inc_in(inc_in), .dec_in(dec_in),
        .count(count), .cpu_clk_en(cpu_clk_en), .step_busy(step_busy), .addr(addr), .addr_chg(addr_chg)
    );

    task automatic chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at %0t: got 0x%0h want 0x%0h", name, $time, act, exp);
        end
    endtask

    // one clock edge as the DUT sees it, using the inputs present now
    function automatic void model_step();
        bit rw[3];
        bit ev[3];
        bit both, flip;
        rw[0] = step_in; rw[1] = inc_in; rw[2] = dec_in;
        if (rst) begin
            for (int b = 0; b < 3; b++) begin
                m_s1[b] = 0; m_s2[b] = 0; m_deb[b] = 0; m_prev[b] = 0; m_h[b] = 0;
                for (int k = 0; k < DEB; k++) hist[b][k] = 0;
            end
            m_phase = 0; m_addr = 0; m_en = 0; m_chg = 0;
            return;
        end
        both = m_deb[1] && m_deb[2];
        ev[0] = 0;
        for (int b = 1; b < 3; b++)
            ev[b] = m_deb[b] && (!m_prev[b] || (m_h[b] >= RD && (m_h[b] - RD) % RP == 0));
        m_en = count || m_phase == 1;
        m_phase = (m_phase == 0) ? (m_deb[0] ? 1 : 0) : (m_phase == 1) ? 2 : (m_deb[0] ? 2 : 0);
        m_chg = ev[1] != ev[2];
        if (ev[1] && !ev[2]) m_addr = (m_addr + 1) % 256;
        else if (ev[2] && !ev[1]) m_addr = (m_addr + 255) % 256;
        for (int b = 1; b < 3; b++) begin
            m_h[b] = (!m_deb[b] || both) ? 0 : m_h[b] + 1;
            m_prev[b] = m_deb[b];
        end
        // debounced level flips once the last DEB synced samples all disagree with it
        for (int b = 0; b < 3; b++) begin
            for (int k = DEB - 1; k > 0; k--) hist[b][k] = hist[b][k-1];
            hist[b][0] = m_s2[b];
            flip = 1;
            for (int k = 0; k < DEB; k++) if (hist[b][k] == m_deb[b]) flip = 0;
            if (flip) m_deb[b] = !m_deb[b];
            m_s2[b] = m_s1[b];
            m_s1[b] = rw[b];
        end
    endfunction

    initial begin
        @(posedge clk_out1);
        forever begin
            @(negedge clk_out1);
            chk("cycle", int'({cpu_clk_en, step_busy, addr_chg, addr}),
                int'({m_en, m_phase != 0, m_chg, 8'(m_addr)}));
            model_step();
        end
    end

    task automatic cyc(int n);
        repeat (n) @(posedge clk_out1);
        #3;
    endtask

    task automatic run(int n, inout int en_n, inout int chg_n);
        repeat (n) begin
            cyc(1);
            en_n += int'(cpu_clk_en);
            chg_n += int'(addr_chg);
        end
    endtask

    initial begin
        int en_n, chg_n, off;
        count = 1'b1;
        cyc(3);
        chk("rst_en", int'(cpu_clk_en), 0);
        chk("rst_busy", int'(step_busy), 0);
        chk("rst_addr", int'(addr), 0);
        chk("rst_chg", int'(addr_chg), 0);
        rst = 1'b0;
        cyc(1);
        chk("en_after_rst", int'(cpu_clk_en), 1);
        count = 1'b0;
        cyc(1);
        chk("en_count0", int'(cpu_clk_en), 0);

        en_n = 0; chg_n = 0; off = -1;
        step_in = 1'b1; run(2, en_n, chg_n);
        step_in = 1'b0; run(2, en_n, chg_n);
        step_in = 1'b1;
        for (int k = 0; k < 50; k++) begin
            cyc(1);
            if (cpu_clk_en) begin
                en_n++;
                if (off < 0) off = k;
            end
        end
        chk("step_pulses", en_n, 1);
        chk("step_latency", off, DEB + 3);
        chk("step_busy_held", int'(step_busy), 1);
        step_in = 1'b0;
        cyc(10);
        chk("step_busy_rel", int'(step_busy), 0);

        rst = 1'b1; cyc(2); rst = 1'b0;
        en_n = 0; chg_n = 0;
        dec_in = 1'b1; run(10, en_n, chg_n);
        dec_in = 1'b0; run(10, en_n, chg_n);
        chk("wrap_dec_addr", int'(addr), 8'hFF);
        chk("wrap_dec_chg", chg_n, 1);
        chg_n = 0;
        repeat (2) begin
            inc_in = 1'b1; run(10, en_n, chg_n);
            inc_in = 1'b0; run(10, en_n, chg_n);
        end
        chk("wrap_inc_addr", int'(addr), 1);
        chk("wrap_inc_chg", chg_n, 2);

        chg_n = 0;
        inc_in = 1'b1; run(60, en_n, chg_n);
        inc_in = 1'b0; run(20, en_n, chg_n);
        chk("rpt_chg", chg_n, 6);
        chk("rpt_addr", int'(addr), 7);

        chg_n = 0;
        inc_in = 1'b1; dec_in = 1'b1; run(40, en_n, chg_n);
        inc_in = 1'b0; dec_in = 1'b0; run(20, en_n, chg_n);
        chk("simul_chg", chg_n, 0);
        chk("simul_addr", int'(addr), 7);

        en_n = 0;
        count = 1'b1; cyc(1); run(10, en_n, chg_n);
        chk("run_mode_en", en_n, 10);
        step_in = 1'b1; cyc(15);
        rst = 1'b1; cyc(1);
        chk("mid_rst_en", int'(cpu_clk_en), 0);
        chk("mid_rst_busy", int'(step_busy), 0);
        chk("mid_rst_addr", int'(addr), 0);
        rst = 1'b0; cyc(1);
        chk("post_rst_en", int'(cpu_clk_en), 1);
        cyc(10);
        chk("held_new_press", int'(step_busy), 1);
        step_in = 1'b0; count = 1'b0; cyc(10);

        repeat (80) begin
            {dec_in, inc_in, step_in} = 3'($urandom);
            count = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 24) == 0);
            cyc(1);
            rst = 1'b0;
            cyc($urandom_range(1, 45));
        end
        {dec_in, inc_in, step_in} = 3'b000;
        cyc(12);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
